// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle shared by the fetch requester, the data requester,
// the arbiter and the single-ported memory macro.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;
    logic              i_err;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [3:0]        d_we;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              d_err;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    // Arbiter view.
    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_we, d_wdata, mem_rdata, mem_ready,
        output i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
        output mem_req, mem_addr, mem_we, mem_wdata
    );

    // Requesters plus memory macro view.
    modport master (
        output i_req, i_addr, d_req, d_addr, d_we, d_wdata, mem_rdata, mem_ready,
        input  i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
        input  mem_req, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the fetch and
// data requesters, with a watchdog that answers stalled accesses with an error.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rstn,
    mem_port_arbiter_if.slave bus
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;
    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;

    state_e            state_q, state_d;
    // The last grant is also the owner of the access in flight.
    owner_e            own_q, own_d;
    owner_e            gnt;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic              i_ack_q, i_ack_d, i_err_q, i_err_d;
    logic              d_ack_q, d_ack_d, d_err_q, d_err_d;

    always_comb begin
        state_d     = state_q;
        own_d       = own_q;
        gnt         = own_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ack_d     = i_ack_q;
        i_err_d     = i_err_q;
        d_ack_d     = d_ack_q;
        d_err_d     = d_err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    if (bus.i_req && bus.d_req) gnt = (own_q == OWN_I) ? OWN_D : OWN_I;
                    else                        gnt = bus.d_req ? OWN_D : OWN_I;
                    own_d       = gnt;
                    mem_addr_d  = (gnt == OWN_D) ? bus.d_addr  : bus.i_addr;
                    mem_we_d    = (gnt == OWN_D) ? bus.d_we    : 4'h0;
                    mem_wdata_d = (gnt == OWN_D) ? bus.d_wdata : '0;
                    mem_req_d   = 1'b1;
                    state_d     = BUS;
                end
            end
            BUS: begin
                // A ready arriving on the timeout cycle still completes normally.
                if (bus.mem_ready) begin
                    if (own_q == OWN_D) begin
                        d_ack_d   = 1'b1;
                        d_err_d   = 1'b0;
                        d_rdata_d = (|mem_we_q) ? '0 : bus.mem_rdata;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_err_d   = 1'b0;
                        i_rdata_d = bus.mem_rdata;
                    end
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = RESP;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    if (own_q == OWN_D) begin
                        d_ack_d   = 1'b1;
                        d_err_d   = 1'b1;
                        d_rdata_d = '0;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_err_d   = 1'b1;
                        i_rdata_d = '0;
                    end
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                // Requests are ignored here so a still-held req cannot re-issue.
                i_ack_d  = 1'b0;
                i_err_d  = 1'b0;
                d_ack_d  = 1'b0;
                d_err_d  = 1'b0;
                mem_we_d = 4'h0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            own_q       <= OWN_I;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 4'h0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ack_q     <= 1'b0;
            i_err_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            own_q       <= own_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ack_q     <= i_ack_d;
            i_err_q     <= i_err_d;
            d_ack_q     <= d_ack_d;
            d_err_q     <= d_err_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.i_ack     = i_ack_q;
    assign bus.i_err     = i_err_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_err     = d_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model with its own memory image.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model state: who was granted last (1 = data) and each port's held rdata.
    logic        last_d;
    logic [31:0] exp_ir, exp_dr;
    logic [31:0] mem [int unsigned];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rd(logic [31:0] a);
        int unsigned k;
        k = a >> 2;
        if (mem.exists(k)) return mem[k];
        return {a[31:2], 2'b01} ^ 32'h5A5A_0000;
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        step();
        step();
        total++;
        if ({bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.i_rdata, bus.i_ack,
             bus.i_err, bus.d_rdata, bus.d_ack, bus.d_err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got mem_req=%b i_ack=%b d_ack=%b mem_addr=%h, want all 0",
                     bus.mem_req, bus.i_ack, bus.d_ack, bus.mem_addr);
        end
        rstn   = 1'b1;
        last_d = 1'b0;
        exp_ir = '0;
        exp_dr = '0;
    endtask

    task automatic test_single_fetch();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h100;
        step();
        total++;
        if ({bus.mem_req, bus.mem_addr, bus.mem_we} !== {1'b1, 32'h100, 4'h0}) begin
            bad++;
            $display("FAIL fetch_bus: got req=%b addr=%h we=%h want 1/00000100/0",
                     bus.mem_req, bus.mem_addr, bus.mem_we);
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000_0013;
        step();
        bus.mem_ready = 1'b0;
        total++;
        if ({bus.i_ack, bus.i_err, bus.d_ack, bus.mem_req, bus.i_rdata} !== {4'b1000, 32'h13}) begin
            bad++;
            $display("FAIL fetch_ack: got ack=%b err=%b d_ack=%b req=%b rdata=%h want 1/0/0/0/00000013",
                     bus.i_ack, bus.i_err, bus.d_ack, bus.mem_req, bus.i_rdata);
        end
        bus.i_req = 1'b0;
        step();
        total++;
        if ({bus.i_ack, bus.mem_req} !== 2'b00) begin
            bad++;
            $display("FAIL fetch_ack_pulse: got ack=%b req=%b want 0/0", bus.i_ack, bus.mem_req);
        end
        last_d = 1'b0;
        exp_ir = 32'h13;
    endtask

    task automatic test_store();
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h2004;
        bus.d_we    = 4'b0011;
        bus.d_wdata = 32'hDEAD_BEEF;
        step();
        for (int c = 1; c <= 4; c++) begin
            total++;
            if ({bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wdata} !==
                {1'b1, 32'h2004, 4'b0011, 32'hDEAD_BEEF}) begin
                bad++;
                $display("FAIL store_hold c%0d: got req=%b addr=%h we=%b wdata=%h", c,
                         bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wdata);
            end
            bus.mem_ready = (c == 4);
            bus.mem_rdata = 32'h1234_5678;
            step();
        end
        bus.mem_ready = 1'b0;
        total++;
        if ({bus.d_ack, bus.d_err, bus.i_ack, bus.d_rdata} !== {3'b100, 32'h0}) begin
            bad++;
            $display("FAIL store_ack: got ack=%b err=%b i_ack=%b rdata=%h want 1/0/0/0",
                     bus.d_ack, bus.d_err, bus.i_ack, bus.d_rdata);
        end
        bus.d_req = 1'b0;
        step();
        total++;
        if ({bus.d_ack, bus.mem_we} !== 5'b0) begin
            bad++;
            $display("FAIL store_resp_clear: got ack=%b we=%b want 0", bus.d_ack, bus.mem_we);
        end
        last_d = 1'b1;
        exp_dr = '0;
    endtask

    task automatic test_tie_order();
        logic exp_d;
        rstn = 1'b0;
        step();
        rstn   = 1'b1;
        exp_ir = '0;
        exp_dr = '0;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h300;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h400;
        bus.d_we   = 4'h0;
        exp_d = 1'b1;
        for (int g = 0; g < 3; g++) begin
            step();
            total++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== (exp_d ? 32'h400 : 32'h300)) begin
                bad++;
                $display("FAIL tie_grant g%0d: got req=%b addr=%h want data=%b", g,
                         bus.mem_req, bus.mem_addr, exp_d);
            end
            bus.mem_ready = 1'b1;
            bus.mem_rdata = 32'h1000 + g;
            step();
            bus.mem_ready = 1'b0;
            total++;
            if ({bus.i_ack, bus.d_ack} !== (exp_d ? 2'b01 : 2'b10)) begin
                bad++;
                $display("FAIL tie_ack g%0d: got i_ack=%b d_ack=%b want data=%b", g,
                         bus.i_ack, bus.d_ack, exp_d);
            end
            if (exp_d) begin bus.d_req = 1'b0; exp_dr = 32'h1000 + g; end
            else       begin bus.i_req = 1'b0; exp_ir = 32'h1000 + g; end
            step();
            total++;
            if ({bus.i_ack, bus.d_ack, bus.mem_req} !== 3'b000) begin
                bad++;
                $display("FAIL tie_resp g%0d: got i_ack=%b d_ack=%b req=%b want 0", g,
                         bus.i_ack, bus.d_ack, bus.mem_req);
            end
            if (exp_d) bus.d_req = 1'b1;
            else       bus.i_req = 1'b1;
            exp_d = !exp_d;
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        step();
        last_d = 1'b1;
    endtask

    task automatic test_timeout();
        int n;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h500;
        step();
        n = 0;
        while (bus.mem_req === 1'b1 && n < 10) begin
            n++;
            step();
        end
        total++;
        if (n != TO) begin
            bad++;
            $display("FAIL timeout_len: got %0d mem_req cycles want %0d", n, TO);
        end
        total++;
        if ({bus.i_ack, bus.i_err, bus.d_ack, bus.i_rdata} !== {3'b110, 32'h0}) begin
            bad++;
            $display("FAIL timeout_resp: got ack=%b err=%b d_ack=%b rdata=%h want 1/1/0/0",
                     bus.i_ack, bus.i_err, bus.d_ack, bus.i_rdata);
        end
        bus.i_req = 1'b0;
        step();
        total++;
        if ({bus.i_ack, bus.i_err, bus.mem_req} !== 3'b000) begin
            bad++;
            $display("FAIL timeout_idle: got ack=%b err=%b req=%b want 0",
                     bus.i_ack, bus.i_err, bus.mem_req);
        end
        last_d = 1'b0;
        exp_ir = '0;
    endtask

    task automatic test_ready_on_timeout();
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h3000;
        bus.d_we   = 4'h0;
        step();
        for (int c = 1; c <= TO; c++) begin
            total++;
            if (bus.mem_req !== 1'b1) begin
                bad++;
                $display("FAIL edge_req c%0d: got %b want 1", c, bus.mem_req);
            end
            bus.mem_ready = (c == TO);
            bus.mem_rdata = (c == TO) ? 32'hCAFE_F00D : 32'hBAD0_0000 + c;
            step();
        end
        bus.mem_ready = 1'b0;
        total++;
        if ({bus.d_ack, bus.d_err, bus.d_rdata} !== {2'b10, 32'hCAFE_F00D}) begin
            bad++;
            $display("FAIL edge_resp: got ack=%b err=%b rdata=%h want 1/0/cafef00d",
                     bus.d_ack, bus.d_err, bus.d_rdata);
        end
        bus.d_req = 1'b0;
        step();
        last_d = 1'b1;
        exp_dr = 32'hCAFE_F00D;
    endtask

    task automatic test_reset_in_bus();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h600;
        step();
        step();
        bus.i_req = 1'b0;
        rstn      = 1'b0;
        step();
        rstn = 1'b1;
        total++;
        if ({bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.i_rdata, bus.i_ack,
             bus.i_err, bus.d_rdata, bus.d_ack, bus.d_err} !== '0) begin
            bad++;
            $display("FAIL bus_reset: got req=%b addr=%h i_rdata=%h d_rdata=%h want 0",
                     bus.mem_req, bus.mem_addr, bus.i_rdata, bus.d_rdata);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if ({bus.i_ack, bus.d_ack, bus.mem_req} !== 3'b000) begin
                bad++;
                $display("FAIL abandoned c%0d: got i_ack=%b d_ack=%b req=%b want 0", c,
                         bus.i_ack, bus.d_ack, bus.mem_req);
            end
        end
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h700;
        bus.d_we   = 4'h0;
        step();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000_0077;
        step();
        bus.mem_ready = 1'b0;
        total++;
        if ({bus.d_ack, bus.d_err, bus.i_ack, bus.d_rdata} !== {3'b100, 32'h77}) begin
            bad++;
            $display("FAIL after_reset: got ack=%b err=%b i_ack=%b rdata=%h want 1/0/0/00000077",
                     bus.d_ack, bus.d_err, bus.i_ack, bus.d_rdata);
        end
        bus.d_req = 1'b0;
        step();
        last_d = 1'b1;
        exp_ir = '0;
        exp_dr = 32'h77;
    endtask

    task automatic test_random();
        for (int r = 0; r < 80; r++) begin
            logic        wi, wd, gd, err;
            logic [31:0] ia, da, dwd, a, wdat, word;
            logic [3:0]  dwe, we;
            int          lat, fin;
            wi  = 1'($urandom_range(1, 0));
            wd  = 1'($urandom_range(1, 0));
            if (!wi && !wd) wd = 1'b1;
            ia  = $urandom & 32'hFFFF_FFFC;
            da  = {20'h0, 10'($urandom), 2'b00};
            dwe = ($urandom_range(1, 0) == 1) ? 4'($urandom_range(15, 1)) : 4'h0;
            dwd = $urandom;
            bus.i_req = wi; bus.i_addr = ia;
            bus.d_req = wd; bus.d_addr = da; bus.d_we = dwe; bus.d_wdata = dwd;
            while (wi || wd) begin
                gd     = (wi && wd) ? !last_d : wd;
                last_d = gd;
                a      = gd ? da : ia;
                we     = gd ? dwe : 4'h0;
                wdat   = gd ? dwd : 32'h0;
                word   = rd(a);
                lat    = $urandom_range(TO + 2, 1);
                fin    = (lat < TO) ? lat : TO;
                err    = (lat > TO);
                step();
                for (int c = 1; c <= fin; c++) begin
                    total++;
                    if ({bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wdata} !== {1'b1, a, we, wdat}) begin
                        bad++;
                        $display("FAIL rnd_bus r%0d c%0d: got req=%b addr=%h we=%b wdata=%h want 1/%h/%b/%h",
                                 r, c, bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wdata, a, we, wdat);
                    end
                    bus.mem_ready = (c == lat);
                    bus.mem_rdata = (c == lat) ? word : $urandom;
                    step();
                end
                bus.mem_ready = 1'b0;
                if (!err && gd && we != 4'h0) begin
                    for (int b = 0; b < 4; b++)
                        if (we[b]) word[8*b +: 8] = dwd[8*b +: 8];
                    mem[a >> 2] = word;
                end
                if (gd) exp_dr = (err || we != 4'h0) ? 32'h0 : word;
                else    exp_ir = err ? 32'h0 : word;
                total++;
                if ({bus.i_ack, bus.d_ack, bus.i_err, bus.d_err, bus.i_rdata, bus.d_rdata} !==
                    {!gd, gd, !gd && err, gd && err, exp_ir, exp_dr}) begin
                    bad++;
                    $display("FAIL rnd_resp r%0d: got ack=%b%b err=%b%b ir=%h dr=%h want ack=%b%b err=%b ir=%h dr=%h",
                             r, bus.i_ack, bus.d_ack, bus.i_err, bus.d_err, bus.i_rdata, bus.d_rdata,
                             !gd, gd, err, exp_ir, exp_dr);
                end
                if (gd) begin wd = 1'b0; bus.d_req = 1'b0; end
                else    begin wi = 1'b0; bus.i_req = 1'b0; end
                step();
                total++;
                if ({bus.i_ack, bus.d_ack, bus.mem_req, bus.mem_we} !== 7'b0) begin
                    bad++;
                    $display("FAIL rnd_resp_clear r%0d: got ack=%b%b req=%b we=%b want 0",
                             r, bus.i_ack, bus.d_ack, bus.mem_req, bus.mem_we);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_req     = 1'b0;
        bus.i_addr    = '0;
        bus.d_req     = 1'b0;
        bus.d_addr    = '0;
        bus.d_we      = 4'h0;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_single_fetch();
        test_store();
        test_tie_order();
        test_timeout();
        test_ready_on_timeout();
        test_reset_in_bus();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch requester and the data (load/store) requester of the multi-cycle RV32 core.
- Uses a req/ack handshake on each requester side and a req/ready handshake on the memory side.
- Grants requests round-robin and enforces a watchdog timeout.
- Sits between the control unit's fetch/memory stages and the memory macro.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must equal 32; byte enables are 4 bits.
- TIMEOUT, 16, maximum memory-wait cycles before an error response; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rstn  in  1  synchronous active-low reset
- i_req  in  1  fetch request; held until i_ack
- i_addr  in  ADDR_W  fetch address; stable while i_req is high
- i_rdata  out  DATA_W  fetched word; valid while i_ack is high
- i_ack  out  1  one-cycle completion pulse for fetch
- i_err  out  1  fetch timed out; valid with i_ack
- d_req  in  1  data request; held until d_ack
- d_addr  in  ADDR_W  data address
- d_we  in  4  byte write enables; 0 means load
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data; valid with d_ack
- d_ack  out  1  one-cycle completion pulse for data
- d_err  out  1  data access timed out; valid with d_ack
- mem_req  out  1  memory access active
- mem_addr  out  ADDR_W  registered address to memory
- mem_we  out  4  registered byte write enables
- mem_wdata  out  DATA_W  registered store data
- mem_rdata  in  DATA_W  memory read data; valid when mem_ready is high
- mem_ready  in  1  memory completes the current access this cycle

Behaviour:
- Reset, taking effect at the clock edge where rstn=0:
  - state goes to IDLE; last_grant goes to I; wait counter goes to 0.
  - Every output goes to 0.
  - An in-flight memory access is abandoned with no ack.
- States: IDLE, BUS, RESP.
- IDLE:
  - No request: stay in IDLE with mem_req=0.
  - Exactly one request: grant that port.
  - Both requesting: grant the port that is not last_grant (data wins the first tie after reset).
  - On grant:
    - Register mem_addr and the grant owner.
    - Register mem_we: d_we for a data grant, 0 for a fetch grant.
    - Register mem_wdata: d_wdata for a data grant, 0 for a fetch grant.
    - Set mem_req=1 and go to BUS.
    - Update last_grant.
- BUS:
  - mem_req=1; mem_addr, mem_we and mem_wdata are held constant.
  - mem_ready=1:
    - Capture mem_rdata into the owner's rdata (store: write 0).
    - Set the owner's ack=1 and err=0.
    - Set mem_req=0 and go to RESP.
  - mem_ready=0: increment the wait counter.
  - Timeout, when TIMEOUT≠0 and the counter reaches TIMEOUT-1 with mem_ready=0:
    - Set the owner's ack=1, err=1 and rdata=0.
    - Set mem_req=0 and go to RESP.
  - mem_ready on the same cycle as the timeout: the ready response wins and err=0.
  - The counter clears on leaving BUS.
- RESP:
  - ack (and err) is high for exactly this one cycle.
  - The requester must drop req by the next edge.
  - Clear ack/err and mem_we, and go to IDLE.
  - Requests are not sampled in RESP, so a held req cannot re-issue.
- Latency:
  - Request seen in IDLE at cycle 0 gives mem_req at cycle 1.
  - mem_ready at cycle k≥1 gives ack at cycle k+1.
  - Minimum request-to-ack is 2 cycles.
  - Back-to-back transactions to the same port have one IDLE cycle between them (3-cycle minimum period).
- rdata holds its last value after ack until the next completion for that port.
- i_ack and d_ack are never high together. mem_req is never high in IDLE or RESP.
- Request signals are not checked for changes mid-transaction; address and data are latched at grant.

Test Plan:
- Reset then single fetch: i_req=1, i_addr=0x100; mem_ready high in the first BUS cycle with mem_rdata=0x00000013 -> mem_req at cycle 1, i_ack pulse at cycle 2, i_rdata=0x00000013, i_err=0, mem_we=0.
- Store: d_req, d_addr=0x2004, d_we=4'b0011, d_wdata=0xDEADBEEF; memory waits 3 cycles -> mem_we=0011 and mem_wdata=0xDEADBEEF held 4 cycles, then d_ack pulse, d_rdata=0.
- Simultaneous i_req and d_req from reset, held -> data granted first, then fetch, then data: grant order D, I, D, strict alternation, no ack overlap.
- Timeout: TIMEOUT=4, fetch with mem_ready held low -> mem_req high exactly 4 cycles, then i_ack=1, i_err=1, i_rdata=0, return to IDLE.
- mem_ready asserted on the exact timeout cycle -> normal ack with err=0 and the captured data.
- rstn=0 for one cycle while in BUS -> next cycle all outputs are 0 and state is IDLE; no ack is generated for the abandoned access; a fresh request then completes normally.
